// File: rtl/tf_modmul_pkg.sv
// Shared types and sizing helpers for the twiddle-factor modular multiplier.
package tf_modmul_pkg;

   localparam int DEFAULT_D_WIDTH = 64;
   localparam int CNT_W = $clog2(DEFAULT_D_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Width of the bit-index counter for a given operand width (at least 1 bit).
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/tf_modmul_step.sv
// One MSB-first interleaved multiply-and-reduce step: acc_next = (2*acc + bit*a) mod n.
module tf_modmul_step #(
   parameter int D_WIDTH = 64
) (
   input  logic [D_WIDTH-1:0] acc,
   input  logic [D_WIDTH-1:0] a,
   input  logic [D_WIDTH-1:0] n,
   input  logic               b_bit,
   output logic [D_WIDTH-1:0] acc_next
);

   localparam int TW = D_WIDTH + 2;

   logic [TW-1:0] n_ext;
   logic [TW-1:0] dbl;
   logic [TW-1:0] red;
   logic [TW-1:0] sum;

   // Two extra bits keep 2*acc + a below 2^(D_WIDTH+2) even for a full-width modulus.
   always_comb begin
      n_ext    = {2'b00, n};
      dbl      = {1'b0, acc, 1'b0};
      red      = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
      sum      = b_bit ? (red + {2'b00, a}) : red;
      acc_next = (sum >= n_ext) ? D_WIDTH'(sum - n_ext) : sum[D_WIDTH-1:0];
   end

endmodule

// File: rtl/tf_modmul_seq.sv
// Sequential twiddle-factor modular multiplier feeding the butterfly R0/R1 operands.
// Define TF_MODMUL_2BIT_EN to retire two multiplier bits per cycle (D_WIDTH must be even).
module tf_modmul_seq
   import tf_modmul_pkg::*;
#(
   parameter int D_WIDTH = DEFAULT_D_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [D_WIDTH-1:0] R0_in,
   input  logic [D_WIDTH-1:0] R1_in,
   input  logic [D_WIDTH-1:0] TF_in,
   input  logic [D_WIDTH-1:0] N_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [D_WIDTH-1:0] R0_out,
   output logic [D_WIDTH-1:0] R1_out
);

   localparam int CW = cnt_width(D_WIDTH);

`ifdef TF_MODMUL_2BIT_EN
   localparam int STEP = 2;
   localparam logic [CW-1:0] LAST_CNT = CW'(1);
`else
   localparam int STEP = 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(0);
`endif

   state_t state_q;
   state_t state_d;

   logic [D_WIDTH-1:0] acc_q;
   logic [D_WIDTH-1:0] a_q;
   logic [D_WIDTH-1:0] b_q;
   logic [D_WIDTH-1:0] n_q;
   logic [D_WIDTH-1:0] r0_q;
   logic [CW-1:0]      cnt_q;
   logic [D_WIDTH-1:0] acc_next;

   logic load;
   logic step_en;
   logic last_step;

   assign last_step = (cnt_q == LAST_CNT);

`ifdef TF_MODMUL_2BIT_EN
   logic [D_WIDTH-1:0] acc_mid;
   logic [CW-1:0]      cnt_lo;

   assign cnt_lo = cnt_q - CW'(1);

   tf_modmul_step #(.D_WIDTH(D_WIDTH)) u_step_hi (
      .acc      (acc_q),
      .a        (a_q),
      .n        (n_q),
      .b_bit    (b_q[cnt_q]),
      .acc_next (acc_mid)
   );

   tf_modmul_step #(.D_WIDTH(D_WIDTH)) u_step_lo (
      .acc      (acc_mid),
      .a        (a_q),
      .n        (n_q),
      .b_bit    (b_q[cnt_lo]),
      .acc_next (acc_next)
   );
`else
   tf_modmul_step #(.D_WIDTH(D_WIDTH)) u_step (
      .acc      (acc_q),
      .a        (a_q),
      .n        (n_q),
      .b_bit    (b_q[cnt_q]),
      .acc_next (acc_next)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      step_en   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step_en = 1'b1;
            if (last_step) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operands are captured once at accept; results only move on the final step, so they hold through DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         n_q    <= '0;
         r0_q   <= '0;
         cnt_q  <= '0;
         R0_out <= '0;
         R1_out <= '0;
      end else if (load) begin
         acc_q <= '0;
         a_q   <= R1_in;
         b_q   <= TF_in;
         n_q   <= N_in;
         r0_q  <= R0_in;
         cnt_q <= CW'(D_WIDTH - 1);
      end else if (step_en) begin
         acc_q <= acc_next;
         cnt_q <= cnt_q - CW'(STEP);
         if (last_step) begin
            R1_out <= acc_next;
            R0_out <= r0_q;
         end
      end
   end

endmodule

// File: doc/tf_modmul_seq.md
Name: tf_modmul_seq

Overview:
- Sequential twiddle-factor modular multiplier; sits directly upstream of the butterfly unit.
- Computes R1_out = (R1_in * TF_in) mod N_in using MSB-first interleaved multiply-and-reduce, one multiplier bit per cycle.
- Passes R0_in through, register-aligned with the product, so R0_out/R1_out feed the butterfly R0/R1 operands directly.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- D_WIDTH, 64, operand/modulus width in bits; must be even when TF_MODMUL_2BIT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands (high only in IDLE)
- R0_in  input  D_WIDTH  butterfly upper operand, passed through
- R1_in  input  D_WIDTH  multiplicand A, precondition A < N_in
- TF_in  input  D_WIDTH  twiddle factor B, precondition B < N_in
- N_in  input  D_WIDTH  modulus, precondition N_in >= 2
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- R0_out  output  D_WIDTH  registered copy of R0_in
- R1_out  output  D_WIDTH  (A*B) mod N

Behaviour:
- Reset, synchronous active-high on clk:
  - state=IDLE, out_valid=0, R0_out=0, R1_out=0.
  - Internal acc, A, B, N and cnt cleared.
  - Reset mid-RUN or mid-DONE discards the operation; in_ready=1 the cycle after reset is released.
- States:
  - IDLE: in_ready=1. in_valid=1 at an edge latches A, B, N, R0, sets acc=0, cnt=D_WIDTH-1, moves to RUN.
  - RUN: in_ready=0. Each edge performs one step on bit B[cnt]:
    - t = 2*acc; if t >= N then t -= N
    - if B[cnt]: t += A; if t >= N then t -= N
    - acc = t; cnt decrements.
    - The step with cnt==0 writes acc into R1_out, the latched R0 into R0_out, sets out_valid=1, and moves to DONE.
  - DONE: out_valid=1; R0_out/R1_out held stable. out_ready=1 at an edge clears out_valid and moves to IDLE.
- Latency: out_valid rises exactly D_WIDTH edges after the accepting edge.
- Initiation interval: D_WIDTH+2 cycles with out_ready tied high.
- Arithmetic: intermediate t held in D_WIDTH+2 bits, so 2*acc+A < 3N never overflows. Each comparison is a full-width unsigned compare. acc < N is an invariant after every step.
- in_valid while not in IDLE is ignored; the upstream must hold operands until in_ready.
- Operands violating A < N or B < N: R1_out is unspecified but the FSM still completes in the normal number of cycles (no hang).
- B=0 or A=0 gives R1_out=0. The full-width modulus (N close to 2^D_WIDTH) is supported.
- out_ready is ignored outside DONE.

Optional Feature:
- TF_MODMUL_2BIT_EN:
  - Defined: two steps are chained per cycle on bits B[cnt] then B[cnt-1]; cnt decrements by 2; latency D_WIDTH/2 edges; II D_WIDTH/2+2.
  - Undefined: one bit per cycle as above.
- Results are bit-identical in both builds.

Decomposition:
- Package tf_modmul_pkg: state enum (IDLE, RUN, DONE), default D_WIDTH, counter width localparam ($clog2(D_WIDTH)).
- Sub-module tf_modmul_step: purely combinational single-bit step (acc, A, N, bit -> acc_next). Instanced once, or twice in series under TF_MODMUL_2BIT_EN.

Test Plan:
- D_WIDTH=8, N=17, A=5, B=7, R0=9 -> R1_out=1, R0_out=9. out_valid exactly 8 edges after accept (4 with TF_MODMUL_2BIT_EN).
- D_WIDTH=8, N=17, A=16, B=16 -> R1_out=1. A=0,B=13 -> 0. A=13,B=0 -> 0.
- D_WIDTH=64, N=0xFFFFFFFF00000001, A=B=0x100000000 -> R1_out=0x00000000FFFFFFFF. A=N-1, B=N-1 -> R1_out=1.
- Backpressure: out_ready low for 5 cycles in DONE -> out_valid, R0_out, R1_out stable. in_ready stays 0. A new in_valid pulse is ignored. Acceptance only after out_ready.
- rst asserted at RUN step 3 -> next cycle out_valid=0, outputs 0, in_ready=1. A following op with N=17, A=3, B=6 -> R1_out=1.
- Random regression: 10k ops, D_WIDTH=64, random N >= 2 and A,B < N, random out_ready -> results match a reference model; the out_valid/out_ready handshake is never violated.
